// File: rtl/psd_stream_pkg.sv
// Shared definitions for the event-packet stream sequencer: state codes,
// default data tags and the 32-bit word layout (tag in the top byte, 24-bit payload).
package psd_stream_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR     = 3'd1;
  localparam state_t ST_ADC_SEL = 3'd2;
  localparam state_t ST_ADC_OUT = 3'd3;
  localparam state_t ST_TDC     = 3'd4;
  localparam state_t ST_TS_LO   = 3'd5;
  localparam state_t ST_TS_HI   = 3'd6;

  localparam logic [7:0] DEF_TAG_HDR   = 8'hA0;
  localparam logic [7:0] DEF_TAG_ADC   = 8'hA1;
  localparam logic [7:0] DEF_TAG_TDC   = 8'hA2;
  localparam logic [7:0] DEF_TAG_TS_LO = 8'hA3;
  localparam logic [7:0] DEF_TAG_TS_HI = 8'hA4;

  localparam int WORD_W  = 32;
  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 24;
  localparam int PAY_MSB = 23;
  localparam int PAY_LSB = 0;

  function automatic logic [WORD_W-1:0] make_word(input logic [7:0] tag,
                                                  input logic [23:0] payload);
    logic [WORD_W-1:0] w;
    w = '0;
    w[TAG_MSB:TAG_LSB] = tag;
    w[PAY_MSB:PAY_LSB] = payload;
    return w;
  endfunction

endpackage

// File: rtl/psd_stream_out_reg.sv
// Output holding register for a valid/ready stream source: the owner loads a word,
// the register presents it until the sink accepts it.
module psd_stream_out_reg
  import psd_stream_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         tready,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  output logic         tlast,
  output logic         accept
);

  // Handshake: a word moves on tvalid & tready; while tvalid & !tready the
  // data/valid/last outputs hold, and tvalid only falls after a transfer.
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;

  assign accept = valid_q & tready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      last_d  = load_last;
    end else if (accept) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign tdata  = data_q;
  assign tvalid = valid_q;
  assign tlast  = last_q;

endmodule

// File: rtl/psd_stream_sequencer.sv
// Builds one event packet (header, ADC words, optional TDC, two timestamp words)
// per accepted start, driving the ADC mux and snapshotting TDC/timestamp at start.
module psd_stream_sequencer
  import psd_stream_pkg::*;
#(
  parameter int         NUM_ADC   = 8,
  parameter logic [7:0] TAG_HDR   = DEF_TAG_HDR,
  parameter logic [7:0] TAG_ADC   = DEF_TAG_ADC,
  parameter logic [7:0] TAG_TDC   = DEF_TAG_TDC,
  parameter logic [7:0] TAG_TS_LO = DEF_TAG_TS_LO,
  parameter logic [7:0] TAG_TS_HI = DEF_TAG_TS_HI
) (
  input  logic        mclk,
  input  logic        mrst_n,
  input  logic        start,
  input  logic        include_tdc,
  input  logic [7:0]  board_id,
  input  logic [15:0] adc_reg,
  output logic [2:0]  adc_mux_sel,
  input  logic [23:0] tdc_reg,
  input  logic [47:0] tstamp,
  input  logic        tready,
  output logic [31:0] tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] event_cnt,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] LAST_SEL = 3'(NUM_ADC - 1);

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [23:0] tdc_snap_q, tdc_snap_d;
  logic [47:0] ts_snap_q, ts_snap_d;
  logic        inc_tdc_q, inc_tdc_d;

  logic        ld;
  logic [31:0] ld_word;
  logic        ld_last;
  logic        accept;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = start && (state_q != ST_IDLE);
    tdc_snap_d = tdc_snap_q;
    ts_snap_d  = ts_snap_q;
    inc_tdc_d  = inc_tdc_q;
    ld         = 1'b0;
    ld_word    = '0;
    ld_last    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        tdc_snap_d = tdc_reg;
        ts_snap_d  = tstamp;
        inc_tdc_d  = include_tdc;
        busy_d     = 1'b1;
        state_d    = ST_HDR;
        ld         = 1'b1;
        ld_word    = make_word(TAG_HDR, {board_id, cnt_q});
      end
      ST_HDR: if (accept) begin
        cnt_d   = cnt_q + 16'd1;
        sel_d   = 3'd0;
        state_d = ST_ADC_SEL;
      end
      // Settle cycle: the mux output is captured straight into the output register.
      ST_ADC_SEL: begin
        ld      = 1'b1;
        ld_word = make_word(TAG_ADC, {5'b0, sel_q, adc_reg});
        state_d = ST_ADC_OUT;
      end
      ST_ADC_OUT: if (accept) begin
        if (sel_q == LAST_SEL) begin
          ld = 1'b1;
          if (inc_tdc_q) begin
            ld_word = make_word(TAG_TDC, tdc_snap_q);
            state_d = ST_TDC;
          end else begin
            ld_word = make_word(TAG_TS_LO, ts_snap_q[23:0]);
            state_d = ST_TS_LO;
          end
        end else begin
          sel_d   = sel_q + 3'd1;
          state_d = ST_ADC_SEL;
        end
      end
      ST_TDC: if (accept) begin
        ld      = 1'b1;
        ld_word = make_word(TAG_TS_LO, ts_snap_q[23:0]);
        state_d = ST_TS_LO;
      end
      ST_TS_LO: if (accept) begin
        ld      = 1'b1;
        ld_word = make_word(TAG_TS_HI, ts_snap_q[47:24]);
        ld_last = 1'b1;
        state_d = ST_TS_HI;
      end
      ST_TS_HI: if (accept) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 3'd0;
      cnt_q      <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tdc_snap_q <= '0;
      ts_snap_q  <= '0;
      inc_tdc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      tdc_snap_q <= tdc_snap_d;
      ts_snap_q  <= ts_snap_d;
      inc_tdc_q  <= inc_tdc_d;
    end
  end

  psd_stream_out_reg #(.W(WORD_W)) u_out (
    .clk       (mclk),
    .rst_n     (mrst_n),
    .load      (ld),
    .load_data (ld_word),
    .load_last (ld_last),
    .tready    (tready),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tlast     (tlast),
    .accept    (accept)
  );

  assign adc_mux_sel = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = ovr_q;
  assign event_cnt   = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_psd_stream_sequencer.sv
// Bench for psd_stream_sequencer: table of packet scenarios plus hand-written
// overrun, mid-packet reset and counter-wrap sequences, all against a packet model.
module tb_psd_stream_sequencer;
  import psd_stream_pkg::*;

  localparam int NUM_ADC = 8;

  logic        mclk = 1'b0;
  logic        mrst_n = 1'b0;
  logic        start = 1'b0;
  logic        include_tdc = 1'b0;
  logic [7:0]  board_id = 8'h00;
  logic [15:0] adc_reg;
  logic [2:0]  adc_mux_sel;
  logic [23:0] tdc_reg = 24'h0;
  logic [47:0] tstamp = 48'h0;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy, done, overrun;
  logic [15:0] event_cnt;
  logic [2:0]  dbg_state;
  logic [15:0] adc_base = 16'h0;

  // External ADC register bank: register i holds adc_base + i.
  assign adc_reg = adc_base + 16'(adc_mux_sel);

  psd_stream_sequencer #(.NUM_ADC(NUM_ADC)) dut (
    .mclk(mclk), .mrst_n(mrst_n), .start(start), .include_tdc(include_tdc),
    .board_id(board_id), .adc_reg(adc_reg), .adc_mux_sel(adc_mux_sel),
    .tdc_reg(tdc_reg), .tstamp(tstamp), .tready(tready), .tdata(tdata),
    .tvalid(tvalid), .tlast(tlast), .busy(busy), .done(done), .overrun(overrun),
    .event_cnt(event_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail = 0;
  int          words_seen = 0;
  int          done_cnt = 0;
  int          ovr_cnt = 0;
  logic [31:0] first_word = '0;
  logic [31:0] exp_q[$];
  logic [15:0] model_cnt = 16'h0;
  logic [31:0] mon_w;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet model: header, NUM_ADC ADC words, optional TDC word, two timestamp words.
  task automatic model_push(input bit inc, input logic [7:0] bid, input logic [23:0] tdc,
                            input logic [47:0] ts, input logic [15:0] base);
    exp_q.push_back({8'hA0, bid, model_cnt});
    model_cnt = model_cnt + 16'd1;
    for (int i = 0; i < NUM_ADC; i++)
      exp_q.push_back({8'hA1, 5'b0, 3'(i), base + 16'(i)});
    if (inc) exp_q.push_back({8'hA2, tdc});
    exp_q.push_back({8'hA3, ts[23:0]});
    exp_q.push_back({8'hA4, ts[47:24]});
  endtask

  always @(negedge mclk) begin
    if (mrst_n) begin
      if (prev_stall)
        check("hold_stable", 64'({tvalid, tlast, tdata}), 64'({1'b1, prev_last, prev_data}));
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_word: actual %0h expected no word", tdata);
        end else begin
          mon_w = exp_q.pop_front();
          check("word", 64'(tdata), 64'(mon_w));
          check("tlast", 64'(tlast), 64'(mon_w[31:24] == 8'hA4));
          if (words_seen == 0) first_word = tdata;
          words_seen++;
        end
      end
      if (done) done_cnt++;
      if (overrun) ovr_cnt++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic run_packet(input bit inc, input logic [7:0] bid, input logic [23:0] tdc,
                            input logic [47:0] ts, input logic [15:0] base, input int rdy_pct,
                            input bit stall3, input bit scramble, input int restart_at,
                            input bit restart_last, output int busy_cycles, output int dones);
    bit          stalled;
    int          stall_left;
    logic [31:0] stall_word;
    stalled = 1'b0;
    stall_left = 0;
    stall_word = '0;
    busy_cycles = 0;
    dones = 0;
    words_seen = 0;
    adc_base = base;
    board_id = bid;
    include_tdc = inc;
    tdc_reg = tdc;
    tstamp = ts;
    start = 1'b1;
    model_push(inc, bid, tdc, ts, base);
    for (int c = 0; c < 400; c++) begin
      @(posedge mclk);
      #1;
      start = 1'b0;
      if (rdy_pct >= 100) tready = 1'b1;
      else tready = (int'($urandom_range(0, 99)) < rdy_pct);
      if (stall3 && !stalled && tvalid && tdata[31:24] == 8'hA1 && tdata[18:16] == 3'd3) begin
        stalled = 1'b1;
        stall_left = 5;
        stall_word = tdata;
      end
      if (stall_left > 0) tready = 1'b0;
      if (scramble) begin
        tdc_reg = 24'($urandom);
        tstamp = {16'($urandom), $urandom};
      end
      start = (c == restart_at) || (restart_last && tvalid && tlast && tready);
      @(negedge mclk);
      if (stall_left > 0) begin
        check("stall_hold", 64'({tvalid, tdata}), 64'({1'b1, stall_word}));
        stall_left--;
      end
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        break;
      end
    end
    start = 1'b0;
    if (dones == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: actual no done expected done within 400 cycles");
    end
    if (stall3) check("stall_seen", 64'(stalled), 64'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          inc;
    logic [7:0]  bid;
    logic [23:0] tdc;
    logic [47:0] ts;
    logic [15:0] base;
    int          rdy_pct;
    bit          stall3;
    bit          scramble;
    int          exp_words;
    int          exp_cycles;
    logic [15:0] exp_hdr_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bc, dn, d0, ri;
    vecs[0] = '{1'b1, 8'h2A, 24'hABCDEF, 48'h123456789ABC, 16'h1000, 100, 1'b0, 1'b0, 12, 20, 16'h0000};
    vecs[1] = '{1'b0, 8'h2A, 24'hABCDEF, 48'h123456789ABC, 16'h1000, 100, 1'b0, 1'b0, 11, 19, 16'h0001};
    vecs[2] = '{1'b1, 8'h2A, 24'hABCDEF, 48'h123456789ABC, 16'h1000, 50, 1'b1, 1'b0, 12, -1, 16'h0002};
    vecs[3] = '{1'b1, 8'h5C, 24'h135790, 48'hFEDCBA987654, 16'h2000, 100, 1'b0, 1'b1, 12, 20, 16'h0003};
    for (int i = 4; i < 6; i++) begin
      ri = int'($urandom_range(0, 1));
      vecs[i].inc = ri[0];
      vecs[i].bid = 8'($urandom);
      vecs[i].tdc = 24'($urandom);
      vecs[i].ts = {16'($urandom), $urandom};
      vecs[i].base = 16'($urandom);
      vecs[i].rdy_pct = (i == 4) ? 100 : 70;
      vecs[i].stall3 = 1'b0;
      vecs[i].scramble = 1'b1;
      vecs[i].exp_words = 1 + NUM_ADC + ri + 2;
      vecs[i].exp_cycles = (i == 4) ? 1 + 2 * NUM_ADC + ri + 2 : -1;
      vecs[i].exp_hdr_cnt = 16'(i);
    end

    // Reset state
    #12;
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_mux_sel", 64'(adc_mux_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_event_cnt", 64'(event_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge mclk);
    mrst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      run_packet(vecs[i].inc, vecs[i].bid, vecs[i].tdc, vecs[i].ts, vecs[i].base,
                 vecs[i].rdy_pct, vecs[i].stall3, vecs[i].scramble, -1, 1'b0, bc, dn);
      idle(3);
      check("words", 64'(words_seen), 64'(vecs[i].exp_words));
      if (vecs[i].exp_cycles >= 0) check("cycles", 64'(bc), 64'(vecs[i].exp_cycles));
      check("done_once", 64'(done_cnt - d0), 64'd1);
      check("hdr_cnt", 64'(first_word[15:0]), 64'(vecs[i].exp_hdr_cnt));
      check("event_cnt", 64'(event_cnt), 64'(vecs[i].exp_hdr_cnt + 16'd1));
      check("busy_idle", 64'({busy, tvalid}), 64'd0);
    end
    check("first_hdr_word", 64'(vecs[0].exp_hdr_cnt), 64'd0);
    check("no_overrun_yet", 64'(ovr_cnt), 64'd0);

    // Overrun: restart 3 cycles in and on the TS_HI accept; then start in the done cycle
    d0 = done_cnt;
    run_packet(1'b1, 8'h2A, 24'hABCDEF, 48'h123456789ABC, 16'h1000, 100, 1'b0, 1'b0, 2, 1'b1, bc, dn);
    check("ovr_words", 64'(words_seen), 64'd12);
    check("ovr_cycles", 64'(bc), 64'd20);
    run_packet(1'b0, 8'h33, 24'h010203, 48'h0A0B0C0D0E0F, 16'h3000, 100, 1'b0, 1'b0, -1, 1'b0, bc, dn);
    idle(3);
    check("after_done_words", 64'(words_seen), 64'd11);
    check("overrun_pulses", 64'(ovr_cnt), 64'd2);
    check("ovr_dones", 64'(done_cnt - d0), 64'd2);
    check("ovr_hdr_cnt", 64'(first_word[15:0]), 64'd7);

    // Reset during ADC word 5
    board_id = 8'h2A; include_tdc = 1'b1; tdc_reg = 24'hABCDEF;
    tstamp = 48'h123456789ABC; adc_base = 16'h1000;
    model_push(1'b1, 8'h2A, 24'hABCDEF, 48'h123456789ABC, 16'h1000);
    start = 1'b1;
    tready = 1'b1;
    dn = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge mclk);
      #1;
      start = 1'b0;
      @(negedge mclk);
      if (tvalid && tdata[31:24] == 8'hA1 && tdata[18:16] == 3'd5) begin
        dn = 1;
        break;
      end
    end
    check("reach_adc5", 64'(dn), 64'd1);
    #2;
    mrst_n = 1'b0;
    #1;
    check("abort_tvalid", 64'(tvalid), 64'd0);
    check("abort_tlast", 64'(tlast), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_event_cnt", 64'(event_cnt), 64'd0);
    exp_q.delete();
    model_cnt = 16'h0;
    repeat (2) @(negedge mclk);
    mrst_n = 1'b1;
    idle(2);
    run_packet(1'b1, 8'h2A, 24'hABCDEF, 48'h123456789ABC, 16'h1000, 100, 1'b0, 1'b0, -1, 1'b0, bc, dn);
    idle(2);
    check("post_reset_hdr", 64'(first_word), 64'h00000000A02A0000);
    check("post_reset_words", 64'(words_seen), 64'd12);

    // Counter wrap: preload the counter to 0xFFFF instead of running 65535 packets
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    model_cnt = 16'hFFFF;
    idle(1);
    run_packet(1'b0, 8'h77, 24'h0, 48'h0, 16'h4000, 100, 1'b0, 1'b0, -1, 1'b0, bc, dn);
    idle(2);
    check("wrap_hdr_ffff", 64'(first_word[15:0]), 64'hFFFF);
    check("wrap_cnt_zero", 64'(event_cnt), 64'd0);
    run_packet(1'b0, 8'h77, 24'h0, 48'h0, 16'h4000, 100, 1'b0, 1'b0, -1, 1'b0, bc, dn);
    idle(2);
    check("wrap_hdr_0000", 64'(first_word[15:0]), 64'h0000);
    check("wrap_cnt_one", 64'(event_cnt), 64'd1);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
